// File: rtl/beehive_tx_frame_arbiter.sv
// beehive_tx_frame_arbiter
//   Frame-granular round-robin arbiter sharing the single Beehive TX path
//   between NUM_SRCS sources. A grant is held from startframe through the
//   endframe transfer, then priority rotates to the source after the winner.
//   Optional per-source completed-frame counters: define
//   BEEHIVE_TX_ARB_STATS_EN to build them; otherwise arb_frame_cnt reads 0.

`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif

module beehive_tx_frame_arbiter #(
  parameter int unsigned NUM_SRCS = 4,
  parameter int unsigned SRC_ID_W = $clog2(NUM_SRCS)
) (
  input  logic                                        clk,
  input  logic                                        rst,

  input  logic [NUM_SRCS-1:0]                         src_arb_tx_val,
  input  logic [NUM_SRCS-1:0]                         src_arb_tx_startframe,
  input  logic [NUM_SRCS-1:0][`MTU_SIZE_W-1:0]        src_arb_tx_frame_size,
  input  logic [NUM_SRCS-1:0]                         src_arb_tx_endframe,
  input  logic [NUM_SRCS-1:0][`MAC_INTERFACE_W-1:0]   src_arb_tx_data,
  input  logic [NUM_SRCS-1:0][`MAC_PADBYTES_W-1:0]    src_arb_tx_padbytes,
  output logic [NUM_SRCS-1:0]                         arb_src_tx_rdy,

  output logic                                        arb_dst_tx_val,
  output logic                                        arb_dst_tx_startframe,
  output logic [`MTU_SIZE_W-1:0]                      arb_dst_tx_frame_size,
  output logic                                        arb_dst_tx_endframe,
  output logic [`MAC_INTERFACE_W-1:0]                 arb_dst_tx_data,
  output logic [`MAC_PADBYTES_W-1:0]                  arb_dst_tx_padbytes,
  input  logic                                        dst_arb_tx_rdy,

  output logic [SRC_ID_W-1:0]                         arb_grant_id,
  output logic                                        arb_frame_err,
  output logic [NUM_SRCS-1:0][31:0]                   arb_frame_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [SRC_ID_W-1:0] LAST_ID = SRC_ID_W'(NUM_SRCS - 1);

  state_e              state_q, state_d;
  logic [SRC_ID_W-1:0] grant_q, grant_d;
  logic [SRC_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic                first_q, first_d;
  logic                err_q, err_d;

  logic [SRC_ID_W-1:0] pick;
  logic                pick_vld;
  logic [SRC_ID_W-1:0] cand_id;
  int unsigned         cand;
  logic                xfer;

  // Round-robin search: first requester at or above rr_ptr, wrapping by
  // explicit compare so non-power-of-2 source counts rotate correctly.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = 0;
    cand_id  = '0;
    for (int unsigned i = 0; i < NUM_SRCS; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_SRCS) begin
        cand = cand - NUM_SRCS;
      end
      cand_id = SRC_ID_W'(cand);
      if (!pick_vld && src_arb_tx_val[cand_id]) begin
        pick_vld = 1'b1;
        pick     = cand_id;
      end
    end
  end

  // Output mux, per-source ready and next-state logic.
  always_comb begin
    arb_src_tx_rdy        = '0;
    arb_dst_tx_val        = 1'b0;
    arb_dst_tx_startframe = 1'b0;
    arb_dst_tx_endframe   = 1'b0;
    arb_dst_tx_frame_size = src_arb_tx_frame_size[grant_q];
    arb_dst_tx_data       = src_arb_tx_data[grant_q];
    arb_dst_tx_padbytes   = src_arb_tx_padbytes[grant_q];
    xfer                  = 1'b0;

    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    first_d  = first_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          first_d = 1'b1;
          state_d = BUSY;
        end
      end

      BUSY: begin
        arb_dst_tx_val          = src_arb_tx_val[grant_q];
        arb_dst_tx_startframe   = src_arb_tx_startframe[grant_q];
        arb_dst_tx_endframe     = src_arb_tx_endframe[grant_q];
        arb_src_tx_rdy[grant_q] = dst_arb_tx_rdy;
        xfer = src_arb_tx_val[grant_q] && dst_arb_tx_rdy;

        if (xfer) begin
          first_d = 1'b0;
          // A grant whose opening beat is not a startframe is flagged but
          // still forwarded untouched.
          if (first_q && !src_arb_tx_startframe[grant_q]) begin
            err_d = 1'b1;
          end
          if (src_arb_tx_endframe[grant_q]) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + SRC_ID_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      first_q  <= first_d;
      err_q    <= err_d;
    end
  end

  assign arb_grant_id  = grant_q;
  assign arb_frame_err = err_q;

`ifdef BEEHIVE_TX_ARB_STATS_EN
  logic [NUM_SRCS-1:0][31:0] frame_cnt_q;

  // Completed-frame counter per source, bumped on each endframe transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (xfer && src_arb_tx_endframe[grant_q]) begin
      frame_cnt_q[grant_q] <= frame_cnt_q[grant_q] + 32'd1;
    end
  end

  assign arb_frame_cnt = frame_cnt_q;
`else
  assign arb_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_beehive_tx_frame_arbiter.sv
// tb_beehive_tx_frame_arbiter
//   Scoreboard bench: directed frames are queued per source and the expected
//   output beats are queued in grant order; a monitor pops and compares each
//   beat the arbiter hands to the converter.

`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif

module tb_beehive_tx_frame_arbiter;

  localparam int NS = 4;
  localparam int IW = $clog2(NS);
  localparam int DW = `MAC_INTERFACE_W;
  localparam int SW = `MTU_SIZE_W;
  localparam int PW = `MAC_PADBYTES_W;

  typedef struct {
    int          src;
    logic [DW-1:0] data;
    logic        sf;
    logic        ef;
    logic [SW-1:0] size;
    logic [PW-1:0] pad;
    int          gap;
    int          exp_cyc;
    int          exp_gap;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NS-1:0]          src_arb_tx_val;
  logic [NS-1:0]          src_arb_tx_startframe;
  logic [NS-1:0][SW-1:0]  src_arb_tx_frame_size;
  logic [NS-1:0]          src_arb_tx_endframe;
  logic [NS-1:0][DW-1:0]  src_arb_tx_data;
  logic [NS-1:0][PW-1:0]  src_arb_tx_padbytes;
  logic [NS-1:0]          arb_src_tx_rdy;
  logic                   arb_dst_tx_val;
  logic                   arb_dst_tx_startframe;
  logic [SW-1:0]          arb_dst_tx_frame_size;
  logic                   arb_dst_tx_endframe;
  logic [DW-1:0]          arb_dst_tx_data;
  logic [PW-1:0]          arb_dst_tx_padbytes;
  logic                   dst_arb_tx_rdy;
  logic [IW-1:0]          arb_grant_id;
  logic                   arb_frame_err;
  logic [NS-1:0][31:0]    arb_frame_cnt;

  beehive_tx_frame_arbiter #(.NUM_SRCS(NS)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .src_arb_tx_val        (src_arb_tx_val),
    .src_arb_tx_startframe (src_arb_tx_startframe),
    .src_arb_tx_frame_size (src_arb_tx_frame_size),
    .src_arb_tx_endframe   (src_arb_tx_endframe),
    .src_arb_tx_data       (src_arb_tx_data),
    .src_arb_tx_padbytes   (src_arb_tx_padbytes),
    .arb_src_tx_rdy        (arb_src_tx_rdy),
    .arb_dst_tx_val        (arb_dst_tx_val),
    .arb_dst_tx_startframe (arb_dst_tx_startframe),
    .arb_dst_tx_frame_size (arb_dst_tx_frame_size),
    .arb_dst_tx_endframe   (arb_dst_tx_endframe),
    .arb_dst_tx_data       (arb_dst_tx_data),
    .arb_dst_tx_padbytes   (arb_dst_tx_padbytes),
    .dst_arb_tx_rdy        (dst_arb_tx_rdy),
    .arb_grant_id          (arb_grant_id),
    .arb_frame_err         (arb_frame_err),
    .arb_frame_cnt         (arb_frame_cnt)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_ef_cyc = 0;
  beat_t srcq [NS][$];
  beat_t exp_q [$];
  logic  rdyq [$];
  int    waited [NS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source drivers: retire beats accepted on this edge, then present the
  // next head beat of each source (after its programmed idle gap).
  always @(posedge clk) begin
    logic [NS-1:0] fire;
    fire = src_arb_tx_val & arb_src_tx_rdy;
    #1;
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        srcq[s].delete();
        waited[s] = 0;
      end
      rdyq.delete();
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (fire[s]) begin
          void'(srcq[s].pop_front());
          waited[s] = 0;
        end
      end
    end
    for (int s = 0; s < NS; s++) begin
      src_arb_tx_val[s]        = 1'b0;
      src_arb_tx_startframe[s] = 1'b0;
      src_arb_tx_endframe[s]   = 1'b0;
      if (srcq[s].size() != 0) begin
        if (waited[s] < srcq[s][0].gap) begin
          waited[s]++;
        end else begin
          src_arb_tx_val[s]        = 1'b1;
          src_arb_tx_startframe[s] = srcq[s][0].sf;
          src_arb_tx_endframe[s]   = srcq[s][0].ef;
          src_arb_tx_data[s]       = srcq[s][0].data;
          src_arb_tx_frame_size[s] = srcq[s][0].size;
          src_arb_tx_padbytes[s]   = srcq[s][0].pad;
        end
      end
    end
    dst_arb_tx_rdy = (rdyq.size() != 0) ? rdyq.pop_front() : 1'b1;
  end

  // Monitor: every beat accepted by the converter must be the next expected one.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && arb_dst_tx_val && dst_arb_tx_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", arb_dst_tx_data, '0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", DW'(arb_grant_id), DW'(e.src));
        chk("src_rdy", DW'(arb_src_tx_rdy), DW'(1 << e.src));
        chk("data", arb_dst_tx_data, e.data);
        chk("startframe", DW'(arb_dst_tx_startframe), DW'(e.sf));
        chk("endframe", DW'(arb_dst_tx_endframe), DW'(e.ef));
        chk("frame_size", DW'(arb_dst_tx_frame_size), DW'(e.size));
        chk("padbytes", DW'(arb_dst_tx_padbytes), DW'(e.pad));
        if (e.exp_cyc != 0) chk("first_beat_cycle", DW'(cyc), DW'(e.exp_cyc));
        if (e.exp_gap != 0) chk("frame_gap", DW'(cyc - last_ef_cyc), DW'(e.exp_gap));
        if (e.ef) last_ef_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input int src, input int nb, input logic [31:0] tag,
                            input logic [SW-1:0] size, input logic [PW-1:0] pad,
                            input bit bad_sf, input int gap_beat, input int gap_len,
                            input int exp_cyc, input int exp_gap);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.src     = src;
      b.data    = DW'({tag, 8'(i)});
      b.sf      = (i == 0) && !bad_sf;
      b.ef      = (i == nb - 1);
      b.size    = size;
      b.pad     = (i == nb - 1) ? pad : '0;
      b.gap     = (i == gap_beat) ? gap_len : 0;
      b.exp_cyc = (i == 0) ? exp_cyc : 0;
      b.exp_gap = (i == 0) ? exp_gap : 0;
      srcq[src].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step(1);
      done = (exp_q.size() == 0);
      for (int s = 0; s < NS; s++) if (srcq[s].size() != 0) done = 1'b0;
    end
    chk(name, DW'(done), DW'(1));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    rst = 1'b0;
    exp_q.delete();
    step(2);
  endtask

  initial begin
    logic [NS-1:0][31:0] exp_cnt;
    bit hit;
    rst = 1'b1;
    src_arb_tx_val = '0;
    src_arb_tx_startframe = '0;
    src_arb_tx_endframe = '0;
    src_arb_tx_data = '0;
    src_arb_tx_frame_size = '0;
    src_arb_tx_padbytes = '0;
    dst_arb_tx_rdy = 1'b1;
    for (int s = 0; s < NS; s++) waited[s] = 0;

    // Reset state
    step(3);
    chk("rst_src_rdy", DW'(arb_src_tx_rdy), '0);
    chk("rst_dst_val", DW'(arb_dst_tx_val), '0);
    chk("rst_grant_id", DW'(arb_grant_id), '0);
    chk("rst_frame_err", DW'(arb_frame_err), '0);
    chk("rst_frame_cnt", DW'(arb_frame_cnt), '0);
    rst = 1'b0;
    step(2);

    // Single source 0, 3-beat frame: first beat one cycle after request
    push_frame(0, 3, 32'h0000_0A00, 16'd150, 6'd2, 1'b0, -1, 0, cyc + 2, 0);
    wait_drain("drain_t1");
    chk("t1_grant_id", DW'(arb_grant_id), DW'(0));

    // Sources 0 and 2 from reset exit: 0, 2, then 0 again, one idle cycle apart
    do_reset(2);
    push_frame(0, 2, 32'h0000_0B00, 16'd100, 6'd1, 1'b0, -1, 0, 0, 0);
    push_frame(2, 2, 32'h0000_0B20, 16'd110, 6'd3, 1'b0, -1, 0, 0, 2);
    push_frame(0, 2, 32'h0000_0B01, 16'd120, 6'd4, 1'b0, -1, 0, 0, 2);
    wait_drain("drain_t2");

    // Single-beat frame on source 3, then pointer wraps to 0
    step(2);
    push_frame(3, 1, 32'h0000_0C30, 16'd60, 6'd5, 1'b0, -1, 0, cyc + 2, 0);
    wait_drain("drain_t3a");
    chk("t3_grant_id", DW'(arb_grant_id), DW'(3));
    push_frame(0, 1, 32'h0000_0C00, 16'd64, 6'd7, 1'b0, -1, 0, 0, 0);
    push_frame(3, 1, 32'h0000_0C31, 16'd65, 6'd8, 1'b0, -1, 0, 0, 2);
    wait_drain("drain_t3b");

    // Backpressure and a source gap mid-frame; source 2 must wait
    step(2);
    rdyq.push_back(1'b1); rdyq.push_back(1'b1); rdyq.push_back(1'b0);
    rdyq.push_back(1'b0); rdyq.push_back(1'b1); rdyq.push_back(1'b0);
    rdyq.push_back(1'b1);
    push_frame(1, 4, 32'h0000_0D10, 16'd250, 6'd9, 1'b0, 2, 2, 0, 0);
    push_frame(2, 1, 32'h0000_0D20, 16'd70, 6'd1, 1'b0, -1, 0, 0, 2);
    wait_drain("drain_t4");
    chk("t4_grant_id", DW'(arb_grant_id), DW'(2));

    // Reset during beat 2 of 4
    step(2);
    push_frame(1, 4, 32'h0000_0E10, 16'd200, 6'd0, 1'b0, -1, 0, 0, 0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step(1);
      hit = (exp_q.size() == 2);
    end
    chk("t5_reached_beat2", DW'(hit), DW'(1));
    rst = 1'b1;
    step(1);
    chk("t5_src_rdy", DW'(arb_src_tx_rdy), '0);
    chk("t5_dst_val", DW'(arb_dst_tx_val), '0);
    chk("t5_grant_id", DW'(arb_grant_id), '0);
    chk("t5_frame_cnt", DW'(arb_frame_cnt), '0);
    exp_q.delete();
    rst = 1'b0;
    push_frame(0, 1, 32'h0000_0E00, 16'd80, 6'd2, 1'b0, -1, 0, 0, 0);
    push_frame(1, 1, 32'h0000_0E11, 16'd81, 6'd3, 1'b0, -1, 0, 0, 2);
    wait_drain("drain_t5");

    // Five frames from source 1, the third missing its startframe
    do_reset(2);
    push_frame(1, 1, 32'h0000_0F10, 16'd40, 6'd1, 1'b0, -1, 0, 0, 0);
    push_frame(1, 2, 32'h0000_0F11, 16'd90, 6'd2, 1'b0, -1, 0, 0, 2);
    wait_drain("drain_t6a");
    chk("t6_err_clean", DW'(arb_frame_err), DW'(0));
    push_frame(1, 2, 32'h0000_0F12, 16'd91, 6'd3, 1'b1, -1, 0, 0, 0);
    push_frame(1, 1, 32'h0000_0F13, 16'd41, 6'd4, 1'b0, -1, 0, 0, 2);
    push_frame(1, 3, 32'h0000_0F14, 16'd180, 6'd5, 1'b0, -1, 0, 0, 2);
    wait_drain("drain_t6b");
    chk("t6_err_sticky", DW'(arb_frame_err), DW'(1));
    chk("t6_grant_id", DW'(arb_grant_id), DW'(1));
    exp_cnt = '0;
`ifdef BEEHIVE_TX_ARB_STATS_EN
    exp_cnt[1] = 32'd5;
`endif
    chk("t6_frame_cnt", DW'(arb_frame_cnt), DW'(exp_cnt));

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
